// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous input in system-clock cycles,
// with a one-cycle valid strobe per measured input cycle and a loss-of-signal timeout.
module period_meter #(
  parameter int COUNT_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 400000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   signal_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [COUNT_WIDTH-1:0] high_time,
  output logic                   period_valid,
  output logic                   timeout
);

  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE     = COUNT_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_d;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] high_cap;
  logic                   sync;
  logic                   rise;
  logic                   fall;

  assign sync = sync_ff[SYNC_STAGES-1];
  assign rise = sync & ~sync_d;
  assign fall = ~sync & sync_d;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, which is what makes the
  // shift chain below a chain rather than a single flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
      sync_d  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], signal_in};
      sync_d  <= sync;
    end
  end

  // Cycles since the last detected rise; parks at the timeout value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_ONE;
    end else if (cnt != TIMEOUT_VAL) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      high_cap     <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      // NOTE: default-assign the strobe first so every path leaves it defined;
      // only the measuring branch raises it, giving a single-cycle pulse.
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          // The first rise only arms: there is no earlier edge to measure from.
          if (rise) begin
            state   <= MEASURE;
            timeout <= 1'b0;
          end
        end
        MEASURE: begin
          if (rise) begin
            period       <= cnt;
            high_time    <= high_cap;
            period_valid <= 1'b1;
          end else if (cnt == TIMEOUT_VAL) begin
            state     <= IDLE;
            timeout   <= 1'b1;
            period    <= '0;
            high_time <= '0;
          end else if (fall) begin
            high_cap <= cnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: square waves, minimum waveform, timeout,
// stuck-high input, mid-measurement reset and period change.
module tb_period_meter;

  localparam int CW = 32;
  localparam int TO = 1000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          signal_in = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_valid;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  // Strobe monitor state, sampled on the falling edge.
  int            cyc = 0;
  int            last_strobe_cyc = 0;
  int            timeout_rise_cyc = 0;
  int            double_strobes = 0;
  logic          prev_valid = 1'b0;
  logic          prev_timeout = 1'b0;
  logic [CW-1:0] p_q[$];
  logic [CW-1:0] h_q[$];

  period_meter #(
    .COUNT_WIDTH   (CW),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .signal_in   (signal_in),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .timeout     (timeout)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (period_valid) begin
      p_q.push_back(period);
      h_q.push_back(high_time);
      last_strobe_cyc = cyc;
      if (prev_valid) double_strobes = double_strobes + 1;
    end
    if (timeout && !prev_timeout) timeout_rise_cyc = cyc;
    prev_valid   = period_valid;
    prev_timeout = timeout;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not reach its end, observed time %0t required < 1ms", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // n input cycles of p clocks each, high for the first h clocks.
  task automatic run_wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      signal_in = 1'b1;
      repeat (h) @(negedge clock);
      signal_in = 1'b0;
      repeat (p - h) @(negedge clock);
    end
  endtask

  // Let pipeline strobes land and step past the monitor's sample point.
  task automatic settle();
    repeat (5) @(negedge clock);
    #1;
  endtask

  task automatic clear_q();
    p_q.delete();
    h_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_period"}, period, '0);
    check({tag, "_high"}, high_time, '0);
    check({tag, "_valid"}, CW'(period_valid), '0);
    check({tag, "_timeout"}, CW'(timeout), '0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check_zero_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // 100/40 square wave: 4 rises, first arms, 3 strobes
    clear_q();
    run_wave(100, 40, 4);
    settle();
    check("sq_count", CW'(p_q.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < p_q.size()) begin
        check($sformatf("sq_period_%0d", i), p_q[i], 100);
        check($sformatf("sq_high_%0d", i), h_q[i], 40);
      end
    end

    // Hold low: timeout exactly TO cycles after the last strobe
    repeat (1100) @(negedge clock);
    #1;
    check("to_level", CW'(timeout), 1);
    check("to_delay", CW'(timeout_rise_cyc - last_strobe_cyc), TO);
    check("to_period", period, 0);
    check("to_high", high_time, 0);
    check("to_no_strobe", CW'(p_q.size()), 3);

    // Recovery: first rise clears timeout silently, second strobes
    clear_q();
    run_wave(100, 40, 2);
    settle();
    check("rec_timeout", CW'(timeout), 0);
    check("rec_count", CW'(p_q.size()), 1);
    if (p_q.size() > 0) begin
      check("rec_period", p_q[0], 100);
      check("rec_high", h_q[0], 40);
    end

    // Period change to 250/125; gap from the last 100-cycle rise is 100+5
    clear_q();
    run_wave(250, 125, 3);
    settle();
    check("chg_count", CW'(p_q.size()), 3);
    if (p_q.size() == 3) begin
      check("chg_trans_period", p_q[0], 105);
      check("chg_trans_high", h_q[0], 40);
      check("chg_period_1", p_q[1], 250);
      check("chg_high_1", h_q[1], 125);
      check("chg_period_2", p_q[2], 250);
      check("chg_high_2", h_q[2], 125);
    end

    // Minimum waveform: 1 high, 1 low
    clear_q();
    run_wave(2, 1, 6);
    settle();
    check("min_count", CW'(p_q.size()), 6);
    if (p_q.size() == 6) begin
      check("min_trans_period", p_q[0], 255);
      check("min_trans_high", h_q[0], 125);
      for (int i = 1; i < 6; i++) begin
        check($sformatf("min_period_%0d", i), p_q[i], 2);
        check($sformatf("min_high_%0d", i), h_q[i], 1);
      end
    end

    // Stuck high: one strobe for the final rise, then timeout with no strobe
    clear_q();
    signal_in = 1'b1;
    repeat (1100) @(negedge clock);
    #1;
    check("stuck_count", CW'(p_q.size()), 1);
    if (p_q.size() > 0) begin
      check("stuck_period", p_q[0], 7);
      check("stuck_high", h_q[0], 1);
    end
    check("stuck_timeout", CW'(timeout), 1);
    check("stuck_to_delay", CW'(timeout_rise_cyc - last_strobe_cyc), TO);
    check("stuck_to_period", period, 0);
    check("stuck_to_high", high_time, 0);

    // Re-arm after stuck high
    signal_in = 1'b0;
    repeat (10) @(negedge clock);
    clear_q();
    run_wave(100, 40, 2);
    settle();
    check("rearm_count", CW'(p_q.size()), 1);
    check("rearm_period", period, 100);
    check("rearm_high", high_time, 40);

    // Reset in the middle of an input cycle
    signal_in = 1'b1;
    repeat (40) @(negedge clock);
    signal_in = 1'b0;
    repeat (30) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("rst_during");
    repeat (3) @(negedge clock);
    #1;
    check_zero_outputs("rst_late");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check_zero_outputs("rst_after");
    repeat (28) @(negedge clock);
    clear_q();
    run_wave(100, 40, 2);
    settle();
    check("rst_count", CW'(p_q.size()), 1);
    if (p_q.size() > 0) begin
      check("rst_period", p_q[0], 100);
      check("rst_high", h_q[0], 40);
    end

    check("strobe_width", CW'(double_strobes), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
